// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side fetch/data ports plus the shared memory bus of the unified-memory arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory environment's view.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;

  logic [1:0]  dm_cmd;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;

  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  if_req, if_addr, dm_cmd, dm_addr, dm_wdata, bus_rdata,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
    output bus_cmd, bus_addr, bus_wdata
  );

  modport slave (
    output if_req, if_addr, dm_cmd, dm_addr, dm_wdata, bus_rdata,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
    input  bus_cmd, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports, one transaction at a time; done arrives
// MEM_LATENCY+2 cycles after a request is first seen idle, and waiting ports are held off via stall.
module mem_bus_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.master arb
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;
  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]  bus_cmd_q, bus_cmd_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        is_load_q, is_load_d;

  logic dm_req;
  logic dm_pend;
  logic if_pend;

  assign dm_req = (arb.dm_cmd == CMD_LOAD) || (arb.dm_cmd == CMD_STORE);

  // A port is stale for the one cycle its done is showing: its request has not dropped yet.
  assign dm_pend = dm_req && !dm_done_q;
  assign if_pend = arb.if_req && !if_done_q;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    bus_cmd_d    = CMD_NONE;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    is_load_d    = is_load_q;

    case (state_q)
      IDLE: begin
        if (dm_pend && (!if_pend || (starve_cnt_q < STARVE_MAX))) begin
          bus_cmd_d   = arb.dm_cmd;
          bus_addr_d  = arb.dm_addr;
          bus_wdata_d = arb.dm_wdata;
          is_load_d   = (arb.dm_cmd == CMD_LOAD);
          lat_cnt_d   = LAT_INIT;
          state_d     = BUSY_D;
          if (if_pend) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_pend) begin
          bus_cmd_d    = CMD_LOAD;
          bus_addr_d   = arb.if_addr;
          bus_wdata_d  = 32'h0;
          lat_cnt_d    = LAT_INIT;
          starve_cnt_d = 4'd0;
          state_d      = BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        // The issue cycle itself is not part of the bus latency, so counting starts after it.
        if (bus_cmd_q != CMD_NONE) begin
          lat_cnt_d = lat_cnt_q;
        end else if (lat_cnt_q == 4'd1) begin
          lat_cnt_d = 4'd0;
          state_d   = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = arb.bus_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (is_load_q) begin
              dm_rdata_d = arb.bus_rdata;
            end
            dm_done_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      bus_cmd_q    <= CMD_NONE;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      if_rdata_q   <= 32'h0;
      dm_rdata_q   <= 32'h0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      is_load_q    <= is_load_d;
    end
  end

  assign arb.bus_cmd   = bus_cmd_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.dm_rdata  = dm_rdata_q;
  assign arb.if_done   = if_done_q;
  assign arb.dm_done   = dm_done_q;
  assign arb.if_stall  = arb.if_req && !if_done_q;
  assign arb.dm_stall  = dm_req && !dm_done_q;

endmodule
